// File: rtl/checksum_stream_if.sv
// Stream bundle for checksum_stream: packet beats in, checksum/byte-count result out.
// Optional out_ok is carried only when CKSUM_VERIFY_EN is defined.
interface checksum_stream_if #(
  parameter int LEN_W = 16
);
  logic [31:0]      in_data;
  logic [3:0]       in_keep;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [15:0]      out_checksum;
  logic [LEN_W-1:0] out_bytes;
  logic             out_valid;
  logic             out_ready;
`ifdef CKSUM_VERIFY_EN
  logic             out_ok;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable while valid is high and ready low.
  modport master (
    output in_data, in_keep, in_valid, in_last, out_ready,
    input  in_ready, out_checksum, out_bytes, out_valid
`ifdef CKSUM_VERIFY_EN
    , input out_ok
`endif
  );

  modport slave (
    input  in_data, in_keep, in_valid, in_last, out_ready,
    output in_ready, out_checksum, out_bytes, out_valid
`ifdef CKSUM_VERIFY_EN
    , output out_ok
`endif
  );
endinterface

// File: rtl/checksum_stream.sv
// Streaming 16-bit ones'-complement checksum and saturating byte count per packet.
// CKSUM_VERIFY_EN adds out_ok (final sum == 0xFFFF, i.e. an embedded checksum verifies).
module checksum_stream #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  checksum_stream_if.slave s,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             rdy_q;
  logic [15:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      cs_q, cs_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  logic             valid_q, valid_d;
`ifdef CKSUM_VERIFY_EN
  logic             ok_q, ok_d;
`endif

  logic             accept;
  logic [31:0]      m;
  logic [17:0]      sum_s;
  logic [16:0]      sum_t;
  logic [15:0]      acc_new;
  logic [2:0]       pop;
  logic [LEN_W:0]   cnt_sum;
  logic [LEN_W-1:0] cnt_new;

  // rdy_q keeps in_ready low during reset and lifts it on the first edge after release.
  assign s.in_ready = rdy_q && (state_q != DONE);
  assign accept     = s.in_valid && s.in_ready;

  assign m = {s.in_data[31:24] & {8{s.in_keep[3]}},
              s.in_data[23:16] & {8{s.in_keep[2]}},
              s.in_data[15:8]  & {8{s.in_keep[1]}},
              s.in_data[7:0]   & {8{s.in_keep[0]}}};

  assign sum_s   = {2'b00, acc_q} + {2'b00, m[31:16]} + {2'b00, m[15:0]};
  assign sum_t   = {1'b0, sum_s[15:0]} + {15'd0, sum_s[17:16]};
  assign acc_new = sum_t[15:0] + {15'd0, sum_t[16]};

  assign pop     = {2'b00, s.in_keep[0]} + {2'b00, s.in_keep[1]}
                 + {2'b00, s.in_keep[2]} + {2'b00, s.in_keep[3]};
  assign cnt_sum = {1'b0, cnt_q} + (LEN_W+1)'(pop);
  assign cnt_new = cnt_sum[LEN_W] ? {LEN_W{1'b1}} : cnt_sum[LEN_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    bytes_d = bytes_q;
    valid_d = valid_q;
`ifdef CKSUM_VERIFY_EN
    ok_d    = ok_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_new;
          cnt_d = cnt_new;
          if (s.in_last) begin
            state_d = DONE;
            valid_d = 1'b1;
            cs_d    = ~acc_new;
            bytes_d = cnt_new;
`ifdef CKSUM_VERIFY_EN
            ok_d    = (acc_new == 16'hFFFF);
`endif
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (s.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          acc_d   = 16'h0000;
          cnt_d   = '0;
`ifdef CKSUM_VERIFY_EN
          ok_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      acc_q   <= 16'h0000;
      cnt_q   <= '0;
      cs_q    <= 16'h0000;
      bytes_q <= '0;
      valid_q <= 1'b0;
`ifdef CKSUM_VERIFY_EN
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      bytes_q <= bytes_d;
      valid_q <= valid_d;
`ifdef CKSUM_VERIFY_EN
      ok_q    <= ok_d;
`endif
    end
  end

  assign s.out_checksum = cs_q;
  assign s.out_bytes    = bytes_q;
  assign s.out_valid    = valid_q;
`ifdef CKSUM_VERIFY_EN
  assign s.out_ok       = ok_q;
`endif
  assign state_o        = state_q;
endmodule

// File: doc/checksum_stream.md
# checksum_stream

Streaming packet checksum engine that accumulates the 16-bit ones'-complement (Internet) checksum over a multi-word packet. It sits directly downstream of the packet source and feeds the header-insert stage. It extends the single-word `checksum` fold (sum of the two 16-bit halves of a 32-bit word, complemented) to arbitrary-length packets using valid/ready handshakes. It also reports the packet byte count.

## Interface
- `LEN_W`, 16, width of the byte counter and of `out_bytes`
- `clk`  input  1  clock; all state changes on the rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `in_data`  input  32  packet word; byte 0 is `[31:24]`, byte 3 is `[7:0]`
- `in_keep`  input  4  byte-lane enables; `in_keep[3]` qualifies `[31:24]`
- `in_valid`  input  1  input beat valid
- `in_last`  input  1  final beat of packet
- `in_ready`  output  1  engine accepts a beat this cycle
- `out_checksum`  output  16  complemented ones'-complement sum
- `out_bytes`  output  LEN_W  count of enabled bytes in packet (saturating)
- `out_valid`  output  1  result valid
- `out_ready`  input  1  downstream accepts result
- `out_ok`  output  1  present only with `CKSUM_VERIFY_EN`; see Configuration

## Operation
- States:
  - IDLE: `in_ready`=1, accumulator 0.
  - ACCUM: `in_ready`=1, mid-packet.
  - DONE: `in_ready`=0, `out_valid`=1.
- A beat is accepted when `in_valid && in_ready`.
- Lane masking: each byte whose `in_keep` bit is 0 is forced to 0x00 before summing. This applies on every beat, not only the last; non-contiguous keep patterns are legal.
- Per accepted beat, with masked word m:
  - s = acc + m[31:16] + m[15:0] (18 bits)
  - t = s[15:0] + s[17:16]
  - acc ← t[15:0] + t[16]
  - This is a single-cycle end-around-carry fold; acc is always 16 bits.
- Byte counter: adds popcount(`in_keep`) per accepted beat. It saturates at 2^LEN_W−1 and never wraps.
- Transitions:
  - IDLE + beat without last → ACCUM.
  - IDLE or ACCUM + beat with last → DONE.
  - ACCUM holds while no beat is accepted.
  - DONE + `out_ready` → IDLE, clearing acc and the byte counter.
- Results: `out_checksum` = ~acc_final, registered; `out_bytes` = final count.
  - A zero-sum packet gives 0xFFFF.
  - acc_final = 0xFFFF gives 0x0000; no substitution of 0x0000 by 0xFFFF.
- A single-beat packet (`in_last` on the first beat) is legal.

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n` is low, 1 from the first edge after release (IDLE).
  - `out_valid`=0, `out_checksum`=0x0000, `out_bytes`=0, `out_ok`=0.
  - State IDLE, acc=0, counter=0.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat. The result is visible the cycle after the last handshake.
- `out_checksum`, `out_bytes` and `out_ok` are stable while `out_valid`=1 && `out_ready`=0.
- `in_ready` is 0 for every DONE cycle. It returns to 1 the cycle after the output handshake, so the minimum gap between packets is 1 cycle.
- `out_valid` falls on the edge where `out_valid && out_ready`.
- `in_data`, `in_keep` and `in_last` are ignored when no beat is accepted.
- `rst_n` asserted mid-packet or in DONE: immediate return to reset values; the partial packet is discarded.

## Configuration
- `CKSUM_VERIFY_EN` defined: adds output `out_ok`, registered alongside `out_checksum`.
  - `out_ok` = 1 iff acc_final == 0xFFFF, i.e. a packet that includes its own checksum field verifies.
  - It is held with `out_valid` and is 0 otherwise.
- Not defined: the `out_ok` port and its logic are absent; all other behaviour is identical.

## Test plan
- Single beat 0x9D2DC3D5, keep 0xF, last → 1 cycle later: `out_valid`=1, `out_checksum`=0x9EFC, `out_bytes`=4.
- Beats 0xFFFF0001, then 0x00000000 with last, keep 0xF → `out_checksum`=0xFFFE, `out_bytes`=8. This exercises the carry fold.
- Single beat 0x12345678, keep 0xC, last → `out_checksum`=0xEDCB, `out_bytes`=2.
- Hold `out_ready`=0 for 3 cycles after a result while the next packet presents `in_valid`=1 → `in_ready`=0 and outputs unchanged throughout. On the handshake: `out_valid`=0, and `in_ready`=1 the next cycle.
- Pulse `rst_n` low after beat 2 of a 4-beat packet, then send 0x9D2DC3D5 with last → 0x9EFC, i.e. no residue from the aborted packet.
- With `CKSUM_VERIFY_EN`: beats 0x9D2DC3D5, then 0x9EFC0000 with last → `out_checksum`=0x0000, `out_ok`=1. Changing the second beat to 0x9EFD0000 → `out_ok`=0.
